// File: rtl/alu_nb_seq.sv
// N-bit registered ALU: logic/compare/shift ops in 1 cycle, unsigned shift-add MUL in WIDTH+1 cycles.
// Valid/ready on both sides; a held result blocks new input until consumed (in_ready follows out_ready).
module alu_nb_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       M,
    input  logic [1:0]       C,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] F_hi,
    output logic             Cout,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        logic             cout;
    } res_t;

    state_t             state, state_nxt;
    res_t               res;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               accept;
    logic               is_mul;

    assign is_mul    = (M == 2'b10) && (C == 2'b10);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    // Depends only on state, out_ready and reset; never on in_valid.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE:    in_ready = 1'b1;
                HOLD:    in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        sum = '0;
        case (C)
            2'b00:   sum = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
            2'b01:   sum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
            2'b10:   sum = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
            default: sum = '0;
        endcase
    end

    // Single-cycle result; MUL is handled by the sequential multiplier below.
    always_comb begin
        res = '0;
        case (M)
            2'b00: begin
                case (C)
                    2'b00:   res.lo = A & B;
                    2'b01:   res.lo = A | B;
                    2'b10:   res.lo = A ^ B;
                    default: res.lo = ~A;
                endcase
            end
            2'b01: begin
                res.lo[2] = (A > B);
                res.lo[1] = (A == B);
                res.lo[0] = (A < B);
            end
            2'b10: begin
                case (C)
                    2'b00: begin
                        res.lo   = {A[WIDTH-2:0], 1'b0};
                        res.cout = A[WIDTH-1];
                    end
                    2'b01: begin
                        res.lo   = {1'b0, A[WIDTH-1:1]};
                        res.cout = A[0];
                    end
                    default: res.lo = A;
                endcase
            end
            default: begin
                case (C)
                    2'b11: begin
                        res.lo   = A - {{(WIDTH-1){1'b0}}, 1'b1};
                        res.cout = |A;
                    end
                    default: begin
                        res.lo   = sum[WIDTH-1:0];
                        res.cout = sum[WIDTH];
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = is_mul ? BUSY : HOLD;
            end
            BUSY: begin
                if (cnt == '0) state_nxt = HOLD;
            end
            HOLD: begin
                if (accept)         state_nxt = is_mul ? BUSY : HOLD;
                else if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            F      <= '0;
            F_hi   <= '0;
            Cout   <= 1'b0;
            zero   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (is_mul) begin
                    mcand  <= {{WIDTH{1'b0}}, A};
                    mplier <= B;
                    prod   <= '0;
                    cnt    <= CW'(WIDTH);
                end else begin
                    F    <= res.lo;
                    F_hi <= res.hi;
                    Cout <= res.cout;
                    zero <= (res.lo == '0) && (res.hi == '0);
                end
            end else if (state == BUSY) begin
                if (cnt != '0) begin
                    prod   <= prod + (mplier[0] ? mcand : '0);
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                end else begin
                    // Product is complete; publish it on the extra cycle after the last step.
                    F    <= prod[WIDTH-1:0];
                    F_hi <= prod[2*WIDTH-1:WIDTH];
                    Cout <= 1'b0;
                    zero <= (prod == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_nb_seq.sv
// Scoreboard bench for alu_nb_seq at WIDTH=4: expected results queued at drive time, checked on output transfer.
module tb_alu_nb_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   M, C;
    logic [W-1:0] A, B;
    logic         Cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] F, F_hi;
    logic         Cout;
    logic         zero;

    typedef struct {
        logic [3:0] f;
        logic [3:0] fh;
        logic       cout;
        logic       zero;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    alu_nb_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .M(M), .C(C), .A(A), .B(B), .Cin(Cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .F(F), .F_hi(F_hi), .Cout(Cout), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int m, input int c, input int a, input int b, input int cin);
        exp_t e;
        int   s;
        e.f = 0; e.fh = 0; e.cout = 0;
        case (m)
            0: case (c)
                0: e.f = 4'(a & b);
                1: e.f = 4'(a | b);
                2: e.f = 4'(a ^ b);
                default: e.f = 4'(15 - a);
            endcase
            1: e.f = (a > b) ? 4'd4 : ((a == b) ? 4'd2 : 4'd1);
            2: case (c)
                0: begin e.f = 4'((a * 2) % 16); e.cout = (a >= 8); end
                1: begin e.f = 4'(a / 2); e.cout = (a % 2 == 1); end
                2: begin s = a * b; e.f = 4'(s % 16); e.fh = 4'(s / 16); end
                default: e.f = 4'(a);
            endcase
            default: case (c)
                0: begin s = a + b + cin; e.f = 4'(s % 16); e.cout = (s >= 16); end
                1: begin s = a - b + 16; e.f = 4'(s % 16); e.cout = (a >= b); end
                2: begin s = a + 1; e.f = 4'(s % 16); e.cout = (s >= 16); end
                default: begin e.f = 4'((a + 15) % 16); e.cout = (a != 0); end
            endcase
        endcase
        e.zero = (e.f == 0) && (e.fh == 0);
        return e;
    endfunction

    // Returns just after the accepting edge.
    task automatic send(input int m, input int c, input int a, input int b, input int cin);
        bit ok = 0;
        sb.push_back(model(m, c, a, b, cin));
        M = 2'(m); C = 2'(c); A = 4'(a); B = 4'(b); Cin = 1'(cin);
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            check("send_timeout", 0, 1);
            void'(sb.pop_back());
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("F", 32'(F), 32'(e.f));
                check("F_hi", 32'(F_hi), 32'(e.fh));
                check("Cout", 32'(Cout), 32'(e.cout));
                check("zero", 32'(zero), 32'(e.zero));
            end
        end
    end

    initial begin
        int  edges;
        bit  seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        M = '0; C = '0; A = '0; B = '0; Cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_F", 32'(F), 0);
        check("rst_F_hi", 32'(F_hi), 0);
        check("rst_Cout", 32'(Cout), 0);
        check("rst_zero", 32'(zero), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        rst_n = 1'b1;
        #1 check("idle_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // Arithmetic and wrap cases
        send(3, 0, 15, 1, 1);
        check("add_latency", 32'(out_valid), 1);
        send(3, 0, 0, 0, 0);
        send(3, 1, 3, 5, 0);
        send(3, 1, 5, 5, 0);
        send(3, 3, 0, 0, 0);
        send(3, 2, 15, 0, 0);

        // Multiplier timing and result
        send(2, 2, 15, 13, 0);
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            edges++;
            check("mul_busy_in_ready", 32'(in_ready), 0);
        end
        check("mul_latency_edges", 32'(edges), W + 1);
        @(posedge clk); #1;
        send(2, 2, 0, 7, 0);
        repeat (W + 3) @(posedge clk);
        #1;

        // Backpressure on an XOR result, then simultaneous transfer
        out_ready = 1'b0;
        send(0, 2, 10, 5, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_F", 32'(F), 15);
            check("bp_in_ready", 32'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(1, 0, 9, 4, 0);
        check("bp_cmp_valid", 32'(out_valid), 1);
        check("bp_cmp_F", 32'(F), 4);

        // Shifts and pass
        send(2, 0, 9, 0, 0);
        send(2, 1, 9, 0, 0);
        send(2, 3, 6, 0, 0);
        @(posedge clk); #1;

        // Reset in the second BUSY cycle of a MUL
        send(2, 2, 7, 9, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_F", 32'(F), 0);
        check("midrst_F_hi", 32'(F_hi), 0);
        check("midrst_in_ready", 32'(in_ready), 0);
        sb.delete();
        rst_n = 1'b1;
        #1 check("midrst_release_ready", 32'(in_ready), 1);
        seen = 0;
        repeat (2 * W + 4) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("midrst_no_result", 32'(seen), 0);
        @(posedge clk); #1;

        // Randomised back-to-back traffic
        for (int i = 0; i < 40; i++) begin
            send($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 1));
        end

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
